// File: rtl/booth_pkg.sv
// Shared types for the sequential radix-2 Booth multiplier: FSM state and
// the {Q[0], q_m1} select encodings.
package booth_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // {Q[0], q_m1}: 2'b11 behaves like NOP as well
   localparam logic [1:0] SEL_NOP = 2'b00;
   localparam logic [1:0] SEL_ADD = 2'b01;
   localparam logic [1:0] SEL_SUB = 2'b10;

endpackage

// File: rtl/booth_step.sv
// One combinational radix-2 Booth step: conditional add/sub of M into A,
// then arithmetic shift right of {A, Q, q_m1} by one bit.
module booth_step
   import booth_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH:0]   a_i,
   input  logic [WIDTH-1:0] q_i,
   input  logic             qm1_i,
   input  logic [WIDTH:0]   m_i,
   output logic [WIDTH:0]   a_o,
   output logic [WIDTH-1:0] q_o,
   output logic             qm1_o
);

   logic [WIDTH:0] sum;

   always_comb begin
      sum = a_i;
      case ({q_i[0], qm1_i})
         SEL_ADD: sum = a_i + m_i;
         SEL_SUB: sum = a_i - m_i;
         default: sum = a_i;
      endcase
   end

   assign a_o   = {sum[WIDTH], sum[WIDTH:1]};
   assign q_o   = {sum[0], q_i[WIDTH-1:1]};
   assign qm1_o = q_i[0];

endmodule

// File: rtl/booth_mul_seq.sv
// Sequential signed WIDTHxWIDTH Booth multiplier, one step per clock, with
// go/busy/done handshake. Optional zero-operand fast path: BOOTH_ZERO_SKIP_EN.
module booth_mul_seq
   import booth_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               go,
   input  logic [WIDTH-1:0]   multiplicand,
   input  logic [WIDTH-1:0]   multiplier,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int CW = $clog2(WIDTH + 1);

   state_t             state_q;
   logic [WIDTH:0]     a_q, m_q;
   logic [WIDTH-1:0]   q_q;
   logic               qm1_q;
   logic [CW-1:0]      cnt_q;
   logic               done_q;
   logic [2*WIDTH-1:0] prod_q;

   logic [WIDTH:0]     a_d;
   logic [WIDTH-1:0]   q_d;
   logic               qm1_d;
   logic               zero_op;

`ifdef BOOTH_ZERO_SKIP_EN
   assign zero_op = (multiplicand == '0) || (multiplier == '0);
`else
   assign zero_op = 1'b0;
`endif

   booth_step #(.WIDTH(WIDTH)) u_step (
      .a_i   (a_q),
      .q_i   (q_q),
      .qm1_i (qm1_q),
      .m_i   (m_q),
      .a_o   (a_d),
      .q_o   (q_d),
      .qm1_o (qm1_d)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         a_q     <= '0;
         m_q     <= '0;
         q_q     <= '0;
         qm1_q   <= 1'b0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         prod_q  <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (go) begin
                  if (zero_op) begin
                     prod_q <= '0;
                     done_q <= 1'b1;
                  end else begin
                     a_q     <= '0;
                     q_q     <= multiplier;
                     qm1_q   <= 1'b0;
                     m_q     <= {multiplicand[WIDTH-1], multiplicand};
                     cnt_q   <= CW'(WIDTH);
                     state_q <= RUN;
                  end
               end
            end
            RUN: begin
               a_q   <= a_d;
               q_q   <= q_d;
               qm1_q <= qm1_d;
               cnt_q <= cnt_q - CW'(1);
               // the step taken with cnt==1 is the final one
               if (cnt_q == CW'(1)) begin
                  prod_q  <= {a_d[WIDTH-1:0], q_d};
                  done_q  <= 1'b1;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy    = (state_q == RUN);
   assign done    = done_q;
   assign product = prod_q;

endmodule

// File: tb/tb_booth_mul_seq.sv
// Scoreboard bench for booth_mul_seq (WIDTH=8): stimulus pushes expected
// product and done cycle, a negedge monitor pops on every done pulse.
module tb_booth_mul_seq;

   localparam int W = 8;

   typedef struct {
      logic [2*W-1:0] prod;
      int             cyc;
   } exp_t;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic           go = 1'b0;
   logic [W-1:0]   multiplicand = '0;
   logic [W-1:0]   multiplier = '0;
   logic           busy, done;
   logic [2*W-1:0] product;

   exp_t sb[$];
   int   cyc = 0;
   int   total_m = 0, bad_m = 0;
   int   total_d = 0, bad_d = 0;

`ifdef BOOTH_ZERO_SKIP_EN
   localparam int ZLAT  = 0;
   localparam int ZBUSY = 0;
`else
   localparam int ZLAT  = W;
   localparam int ZBUSY = W;
`endif

   booth_mul_seq #(.WIDTH(W)) dut (
      .clk          (clk),
      .reset        (reset),
      .go           (go),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .busy         (busy),
      .done         (done),
      .product      (product)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // monitor: every done pulse must match the oldest expected result
   always @(negedge clk) begin
      if (!reset && done) begin
         total_m++;
         if (sb.size() == 0) begin
            bad_m++;
            $display("FAIL spurious_done: cyc=%0d product=%h, no result expected", cyc, product);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if (product !== e.prod || cyc != e.cyc) begin
               bad_m++;
               $display("FAIL result: product=%h at cyc=%0d, want %h at cyc=%0d",
                        product, cyc, e.prod, e.cyc);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total_d++;
      if (act !== req) begin
         bad_d++;
         $display("FAIL %s: got %0h want %0h", name, act, req);
      end
   endtask

   // issue one operation from a negedge; DUT must be idle
   task automatic start(input logic [W-1:0] m, input logic [W-1:0] q,
                        input logic [2*W-1:0] exp, input int lat, input bit push);
      multiplicand = m;
      multiplier   = q;
      go           = 1'b1;
      if (push) sb.push_back('{exp, cyc + 1 + lat});
      @(negedge clk);
      go = 1'b0;
   endtask

   task automatic run(input logic [W-1:0] m, input logic [W-1:0] q, input logic [2*W-1:0] exp);
      start(m, q, exp, W, 1'b1);
      repeat (W + 2) @(negedge clk);
   endtask

   initial begin
      int nb;
      int acc;
      repeat (3) @(negedge clk);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_done", 32'(done), 32'd0);
      chk("reset_product", 32'(product), 32'd0);
      reset = 1'b0;
      @(negedge clk);

      // 7 x -3, busy for exactly W cycles
      start(8'd7, 8'hFD, 16'hFFEB, W, 1'b1);
      nb = 0;
      repeat (12) begin
         if (busy) nb++;
         @(negedge clk);
      end
      chk("busy_cycles", 32'(nb), 32'(W));
      chk("product_hold", 32'(product), 32'hFFEB);

      run(8'h80, 8'h80, 16'h4000);
      run(8'h80, 8'h7F, 16'hC080);
      run(8'h7F, 8'h7F, 16'h3F01);
      run(8'hFF, 8'hFF, 16'h0001);

      // go pulsed mid-RUN must be ignored
      start(8'd5, 8'd6, 16'h001E, W, 1'b1);
      repeat (2) @(negedge clk);
      multiplicand = 8'd9; multiplier = 8'd9; go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      repeat (W + 2) @(negedge clk);
      chk("ignored_go_product", 32'(product), 32'h001E);

      // go held high: back-to-back acceptance in the done cycle
      multiplicand = 8'd3; multiplier = 8'd4; go = 1'b1;
      acc = cyc + 1;
      sb.push_back('{16'h000C, acc + W});
      sb.push_back('{16'hFFFC, acc + W + 1 + W});
      @(negedge clk);
      multiplicand = 8'd2; multiplier = 8'hFE;
      while (cyc < acc + W + 2) @(negedge clk);
      go = 1'b0;
      repeat (W + 2) @(negedge clk);

      // reset mid-RUN aborts with product cleared
      start(8'd3, 8'd4, 16'h0, W, 1'b0);
      repeat (3) @(negedge clk);
      chk("pre_abort_busy", 32'(busy), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_product", 32'(product), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      run(8'd3, 8'd4, 16'h000C);

      // zero operand: fast path or full length depending on build
      start(8'd0, 8'hFB, 16'h0000, ZLAT, 1'b1);
      nb = 0;
      repeat (12) begin
         if (busy) nb++;
         @(negedge clk);
      end
      chk("zero_busy_cycles", 32'(nb), 32'(ZBUSY));
      chk("zero_product", 32'(product), 32'd0);

      nb = 0;
      while (sb.size() != 0 && nb < 50) begin
         nb++;
         @(negedge clk);
      end
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total_m + total_d, bad_m + bad_d);
      $finish;
   end

endmodule
